multi_timer: RTL and testbench

//  N_CH independent programmable countdown timers. Each channel has its own clock prescaler that

---
 rtl/timer_pkg.sv | 12 +
 rtl/tick_divider.sv | 38 +++
 rtl/multi_timer.sv | 109 ++++++++++
 tb/tb_multi_timer.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/timer_pkg.sv
// Shared types and elaboration helpers for the multi-channel countdown timer.
package timer_pkg;

  typedef enum logic {CH_IDLE, CH_RUN} ch_state_t;

  // Clock cycles per tick; 0 flags an unusable tick rate.
  function automatic int unsigned calc_div(input int unsigned clk_hz, input int unsigned tick_hz);
    if (tick_hz == 0) return 0;
    return clk_hz / tick_hz;
  endfunction

endpackage

// File: rtl/tick_divider.sv
// Free-running prescaler: emits a one-cycle tick when it wraps from DIV-1 to 0.
module tick_divider #(
  parameter int unsigned DIV = 10
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic en,
  output logic tick
);

  localparam int unsigned DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DIV_W-1:0] LAST = DIV_W'(DIV - 1);

  logic [DIV_W-1:0] pre_q;
  logic [DIV_W-1:0] pre_d;

  always_comb begin
    pre_d = pre_q;
    if (clear) begin
      pre_d = '0;
    end else if (en) begin
      pre_d = (pre_q == LAST) ? '0 : pre_q + DIV_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pre_q <= '0;
    end else begin
      pre_q <= pre_d;
    end
  end

  // A clear on the same edge (start/stop) swallows the tick.
  assign tick = en && !clear && (pre_q == LAST);

endmodule

// File: rtl/multi_timer.sv
// N_CH independent countdown timers with one-shot/periodic modes, hold and stop.
module multi_timer
  import timer_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ = 50_000_000,
  parameter int unsigned TICK_HZ     = 1,
  parameter int unsigned N_CH        = 4,
  parameter int unsigned CNT_W       = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [N_CH-1:0]         start,
  input  logic [N_CH-1:0]         stop,
  input  logic [N_CH-1:0]         hold,
  input  logic [N_CH-1:0]         periodic,
  input  logic [N_CH*CNT_W-1:0]   load_val,
  output logic [N_CH*CNT_W-1:0]   count,
  output logic [N_CH-1:0]         running,
  output logic [N_CH-1:0]         expired
);

  localparam int unsigned DIV = calc_div(CLK_FREQ_HZ, TICK_HZ);

  if (DIV < 2 || (DIV * TICK_HZ) != CLK_FREQ_HZ) begin : g_bad_div
    $error("multi_timer: CLK_FREQ_HZ/TICK_HZ must be an integer >= 2");
  end
  if (N_CH < 1) begin : g_bad_nch
    $error("multi_timer: N_CH must be >= 1");
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    ch_state_t        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] reload_q, reload_d;
    logic             mode_q, mode_d;
    logic             exp_q, exp_d;
    logic             clear, en, tick, run_o;
    logic [CNT_W-1:0] ld;

    assign ld = load_val[i*CNT_W +: CNT_W];

    tick_divider #(.DIV(DIV)) u_div (
      .clk   (clk),
      .reset (reset),
      .clear (clear),
      .en    (en),
      .tick  (tick)
    );

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        state_q  <= CH_IDLE;
        cnt_q    <= '0;
        reload_q <= '0;
        mode_q   <= 1'b0;
        exp_q    <= 1'b0;
      end else begin
        state_q  <= state_d;
        cnt_q    <= cnt_d;
        reload_q <= reload_d;
        mode_q   <= mode_d;
        exp_q    <= exp_d;
      end
    end

    // Priority: stop > start > hold > tick. Zero load behaves as stop.
    always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      reload_d = reload_q;
      mode_d   = mode_q;
      exp_d    = 1'b0;
      clear    = 1'b0;
      if (stop[i] || (start[i] && ld == '0)) begin
        state_d = CH_IDLE;
        cnt_d   = '0;
        clear   = 1'b1;
      end else if (start[i]) begin
        state_d  = CH_RUN;
        cnt_d    = ld;
        reload_d = ld;
        mode_d   = periodic[i];
        clear    = 1'b1;
      end else if (tick) begin
        if (cnt_q == CNT_W'(1)) begin
          exp_d = 1'b1;
          if (mode_q) begin
            cnt_d = reload_q;
          end else begin
            cnt_d   = '0;
            state_d = CH_IDLE;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
    end

    always_comb begin
      run_o = (state_q == CH_RUN);
      en    = run_o && !hold[i];
    end

    assign count[i*CNT_W +: CNT_W] = cnt_q;
    assign running[i]              = run_o;
    assign expired[i]              = exp_q;
  end

endmodule

// File: tb/tb_multi_timer.sv
// Bench for multi_timer: directed scenarios plus random traffic against a cycles-remaining model.
module tb_multi_timer;

  localparam int N_CH  = 2;
  localparam int CNT_W = 8;
  localparam int DIV   = 10;

  logic                  clk;
  logic                  reset;
  logic [N_CH-1:0]       start, stop, hold, periodic;
  logic [N_CH*CNT_W-1:0] load_val;
  logic [N_CH*CNT_W-1:0] count;
  logic [N_CH-1:0]       running, expired;

  int checks = 0;
  int errors = 0;

  // Reference: each channel tracks clock cycles left until expiry.
  bit m_run [N_CH];
  bit m_per [N_CH];
  bit m_exp [N_CH];
  int m_rem [N_CH];
  int m_len [N_CH];

  multi_timer #(
    .CLK_FREQ_HZ (10),
    .TICK_HZ     (1),
    .N_CH        (N_CH),
    .CNT_W       (CNT_W)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .stop     (stop),
    .hold     (hold),
    .periodic (periodic),
    .load_val (load_val),
    .count    (count),
    .running  (running),
    .expired  (expired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic mdl_reset();
    for (int c = 0; c < N_CH; c++) begin
      m_run[c] = 0; m_per[c] = 0; m_exp[c] = 0; m_rem[c] = 0; m_len[c] = 0;
    end
  endtask

  task automatic mdl_step();
    for (int c = 0; c < N_CH; c++) begin
      int lv;
      lv = int'(load_val[c*CNT_W +: CNT_W]);
      m_exp[c] = 0;
      if (stop[c]) begin
        m_run[c] = 0; m_rem[c] = 0;
      end else if (start[c]) begin
        if (lv != 0) begin
          m_run[c] = 1; m_rem[c] = lv * DIV; m_len[c] = lv; m_per[c] = periodic[c];
        end else begin
          m_run[c] = 0; m_rem[c] = 0;
        end
      end else if (m_run[c] && !hold[c]) begin
        m_rem[c] = m_rem[c] - 1;
        if (m_rem[c] == 0) begin
          m_exp[c] = 1;
          if (m_per[c]) m_rem[c] = m_len[c] * DIV;
          else m_run[c] = 0;
        end
      end
    end
  endtask

  function automatic logic [N_CH*CNT_W-1:0] mdl_count();
    logic [N_CH*CNT_W-1:0] v;
    v = '0;
    for (int c = 0; c < N_CH; c++)
      if (m_run[c]) v[c*CNT_W +: CNT_W] = CNT_W'((m_rem[c] + DIV - 1) / DIV);
    return v;
  endfunction

  function automatic logic [N_CH-1:0] mdl_running();
    logic [N_CH-1:0] v;
    for (int c = 0; c < N_CH; c++) v[c] = m_run[c];
    return v;
  endfunction

  function automatic logic [N_CH-1:0] mdl_expired();
    logic [N_CH-1:0] v;
    for (int c = 0; c < N_CH; c++) v[c] = m_exp[c];
    return v;
  endfunction

  task automatic tick_clk();
    @(posedge clk);
    mdl_step();
    #1;
  endtask

  task automatic clear_inputs();
    start = '0; stop = '0; hold = '0; periodic = '0; load_val = '0;
  endtask

  task automatic idle_all();
    clear_inputs();
    stop = '1;
    tick_clk();
    stop = '0;
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 1'b1;
    mdl_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (count !== '0 || running !== '0 || expired !== '0) begin
      errors++;
      $display("FAIL reset_state got count=%h run=%b exp=%b want 0", count, running, expired);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_one_shot();
    idle_all();
    for (int e = 0; e <= 45; e++) begin
      start[0] = (e == 5); periodic[0] = 1'b0; load_val[CNT_W-1:0] = 8'd3;
      tick_clk();
      checks++;
      if (count !== mdl_count() || running !== mdl_running() || expired !== mdl_expired()) begin
        errors++;
        $display("FAIL one_shot_model e=%0d got %h/%b/%b want %h/%b/%b", e, count, running, expired,
                 mdl_count(), mdl_running(), mdl_expired());
      end
      checks++;
      if (expired[0] !== (e == 35)) begin
        errors++;
        $display("FAIL one_shot_expiry e=%0d got %b want %b", e, expired[0], e == 35);
      end
      if (e == 15 || e == 25 || e == 35) begin
        checks++;
        if (count[CNT_W-1:0] !== CNT_W'(e == 15 ? 2 : (e == 25 ? 1 : 0))) begin
          errors++;
          $display("FAIL one_shot_count e=%0d got %0d", e, count[CNT_W-1:0]);
        end
      end
    end
  endtask

  task automatic test_periodic();
    idle_all();
    for (int e = 0; e <= 65; e++) begin
      start[1] = (e == 0); periodic[1] = 1'b1; load_val[CNT_W +: CNT_W] = 8'd2;
      tick_clk();
      checks++;
      if (count !== mdl_count() || running !== mdl_running() || expired !== mdl_expired()) begin
        errors++;
        $display("FAIL periodic_model e=%0d got %h/%b/%b want %h/%b/%b", e, count, running, expired,
                 mdl_count(), mdl_running(), mdl_expired());
      end
      checks++;
      if (expired[1] !== (e == 20 || e == 40 || e == 60) || running[1] !== 1'b1) begin
        errors++;
        $display("FAIL periodic_pulse e=%0d got exp=%b run=%b", e, expired[1], running[1]);
      end
    end
  endtask

  task automatic test_hold();
    idle_all();
    for (int e = 0; e <= 25; e++) begin
      start[0] = (e == 0); load_val[CNT_W-1:0] = 8'd1;
      hold[0] = (e >= 3 && e <= 9);
      tick_clk();
      checks++;
      if (count !== mdl_count() || running !== mdl_running() || expired !== mdl_expired()) begin
        errors++;
        $display("FAIL hold_model e=%0d got %h/%b/%b want %h/%b/%b", e, count, running, expired,
                 mdl_count(), mdl_running(), mdl_expired());
      end
      checks++;
      if (expired[0] !== (e == 17) || (e < 17 && count[CNT_W-1:0] !== 8'd1)) begin
        errors++;
        $display("FAIL hold_expiry e=%0d got exp=%b cnt=%0d", e, expired[0], count[CNT_W-1:0]);
      end
    end
  endtask

  task automatic test_priority();
    idle_all();
    start[0] = 1'b1; stop[0] = 1'b1; load_val[CNT_W-1:0] = 8'd3;
    tick_clk();
    clear_inputs();
    checks++;
    if (running[0] !== 1'b0 || count[CNT_W-1:0] !== 8'd0) begin
      errors++;
      $display("FAIL prio_start_stop got run=%b cnt=%0d want 0/0", running[0], count[CNT_W-1:0]);
    end
    for (int e = 0; e <= 40; e++) begin
      start[0] = (e == 0 || e == 4);
      load_val[CNT_W-1:0] = (e == 4) ? 8'd0 : 8'd3;
      tick_clk();
      checks++;
      if (expired[0] !== 1'b0 || (e >= 4 && (running[0] !== 1'b0 || count[CNT_W-1:0] !== 8'd0))) begin
        errors++;
        $display("FAIL prio_zero_load e=%0d got run=%b cnt=%0d exp=%b", e, running[0],
                 count[CNT_W-1:0], expired[0]);
      end
    end
    for (int e = 0; e <= 25; e++) begin
      start[0] = (e == 0 || e == 7); load_val[CNT_W-1:0] = 8'd1;
      tick_clk();
      checks++;
      if (expired[0] !== (e == 17) || expired !== mdl_expired()) begin
        errors++;
        $display("FAIL prio_restart e=%0d got %b want %b", e, expired[0], e == 17);
      end
    end
  endtask

  task automatic test_reset_mid_run();
    idle_all();
    for (int e = 0; e <= 12; e++) begin
      start = (e == 0) ? 2'b11 : 2'b00; periodic = 2'b10; load_val = {8'd5, 8'd3};
      tick_clk();
    end
    #3 reset = 1'b1;
    #1;
    checks++;
    if (count !== '0 || running !== '0 || expired !== '0) begin
      errors++;
      $display("FAIL reset_async got count=%h run=%b exp=%b want 0", count, running, expired);
    end
    repeat (2) @(posedge clk);
    #3 reset = 1'b0;
    mdl_reset();
    for (int e = 0; e < 60; e++) begin
      tick_clk();
      checks++;
      if (count !== '0 || running !== '0 || expired !== '0) begin
        errors++;
        $display("FAIL reset_after e=%0d got count=%h run=%b exp=%b", e, count, running, expired);
      end
    end
    test_one_shot();
  endtask

  task automatic test_independence();
    idle_all();
    for (int e = 0; e <= 60; e++) begin
      start[0] = (e == 0 || e == 25);
      load_val[CNT_W-1:0] = (e == 25) ? 8'd3 : 8'd2;
      start[1] = (e == 0); periodic = 2'b10; load_val[CNT_W +: CNT_W] = 8'd1;
      stop[1] = (e == 35);
      tick_clk();
      checks++;
      if (count !== mdl_count() || running !== mdl_running() || expired !== mdl_expired()) begin
        errors++;
        $display("FAIL indep_model e=%0d got %h/%b/%b want %h/%b/%b", e, count, running, expired,
                 mdl_count(), mdl_running(), mdl_expired());
      end
      checks++;
      if (expired[0] !== (e == 20 || e == 55) ||
          expired[1] !== (e > 0 && e <= 30 && e % 10 == 0)) begin
        errors++;
        $display("FAIL indep_pulse e=%0d got %b", e, expired);
      end
    end
  endtask

  task automatic test_random();
    idle_all();
    for (int n = 0; n < 3000; n++) begin
      for (int c = 0; c < N_CH; c++) begin
        start[c]    = ($urandom_range(0, 11) == 0);
        stop[c]     = ($urandom_range(0, 39) == 0);
        periodic[c] = 1'($urandom_range(0, 1));
        if ($urandom_range(0, 7) == 0) hold[c] = ~hold[c];
        load_val[c*CNT_W +: CNT_W] = CNT_W'($urandom_range(0, 4));
      end
      tick_clk();
      checks++;
      if (count !== mdl_count() || running !== mdl_running() || expired !== mdl_expired()) begin
        errors++;
        $display("FAIL random_model n=%0d got %h/%b/%b want %h/%b/%b", n, count, running, expired,
                 mdl_count(), mdl_running(), mdl_expired());
      end
    end
  endtask

  initial begin
    test_reset();
    test_one_shot();
    test_periodic();
    test_hold();
    test_priority();
    test_reset_mid_run();
    test_independence();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
